// File: rtl/mem_stage_responder.sv
// Memory-stage load/store responder: data RAM, LED register, free-running cycle
// counter and a FIFO-buffered 8N1 UART transmitter, with same-cycle load data.
module mem_stage_responder #(
    parameter int RAM_WORDS    = 512,
    parameter int FIFO_DEPTH   = 8,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] addr,
    input  logic [63:0] wdata,
    input  logic        wmem,
    input  logic        rmem,
    input  logic [2:0]  func3,
    output logic [63:0] rdata,
    output logic [7:0]  leds,
    output logic        uart_tx,
    output logic        fault
);

    localparam int AW = $clog2(RAM_WORDS);
    localparam int FW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(CLKS_PER_BIT + 1);

    localparam logic [63:0] LED_ADDR  = 64'h0000_0000_1000_0000;
    localparam logic [63:0] UART_ADDR = 64'h0000_0000_1000_0008;
    localparam logic [63:0] CYC_ADDR  = 64'h0000_0000_1000_0010;

    localparam logic [FW:0]   DEPTH_CNT = (FW + 1)'(FIFO_DEPTH);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    logic [63:0]   ram_q [RAM_WORDS];
    logic [7:0]    fifo_q [FIFO_DEPTH];

    logic [7:0]    leds_q, leds_d;
    logic [63:0]   cyc_q, cyc_d;
    logic          fault_q, fault_d;
    logic          ovf_q, ovf_d;
    logic [FW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FW:0]   count_q, count_d;
    logic [1:0]    state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;

    logic [1:0]    size;
    logic          access, misaligned, bad, ok;
    logic          ram_hit, led_hit, uart_hit, cyc_hit, periph_hit;
    logic [AW-1:0] ram_idx;
    logic [63:0]   ram_lane, periph_raw, raw, pw, wlane;
    logic [7:0]    byte_mask, be;
    logic          ram_we, led_we, cyc_we, push, push_ok, pop, baud_done;
    logic [63:0]   uart_status;

    function automatic logic [63:0] extend(input logic [63:0] v, input logic [1:0] sz,
                                           input logic uns);
        case (sz)
            2'd0:    return uns ? {56'b0, v[7:0]}  : {{56{v[7]}}, v[7:0]};
            2'd1:    return uns ? {48'b0, v[15:0]} : {{48{v[15]}}, v[15:0]};
            2'd2:    return uns ? {32'b0, v[31:0]} : {{32{v[31]}}, v[31:0]};
            default: return v;
        endcase
    endfunction

    // Address/size decode; any illegal access is squashed entirely and only raises fault.
    always_comb begin
        size       = func3[1:0];
        access     = wmem | rmem;
        ram_idx    = addr[AW+2:3];
        ram_hit    = (addr >> (AW + 3)) == 64'd0;
        led_hit    = addr == LED_ADDR;
        uart_hit   = addr == UART_ADDR;
        cyc_hit    = addr == CYC_ADDR;
        periph_hit = led_hit | uart_hit | cyc_hit;
        case (size)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = addr[0];
            2'd2:    misaligned = |addr[1:0];
            default: misaligned = |addr[2:0];
        endcase
        bad = (func3 == 3'b111) | (wmem & func3[2]) | misaligned
            | ~(ram_hit | periph_hit) | (periph_hit & ~size[1]);
        ok  = access & ~bad;
    end

    always_comb begin
        uart_status = {48'b0, {(7 - FW){1'b0}}, count_q, 3'b0, ovf_q,
                       count_q == DEPTH_CNT, count_q == '0, state_q != ST_IDLE, 1'b0};
        ram_lane    = ram_q[ram_idx] >> {addr[2:0], 3'b000};
        if (led_hit)
            periph_raw = {56'b0, leds_q};
        else if (uart_hit)
            periph_raw = uart_status;
        else
            periph_raw = cyc_q;
        raw   = ram_hit ? ram_lane : periph_raw;
        rdata = (rmem && ok) ? extend(raw, size, func3[2]) : 64'd0;
    end

    // Store path: lane-shifted data with byte enables for RAM, size-trimmed data for peripherals.
    always_comb begin
        case (size)
            2'd0:    byte_mask = 8'h01;
            2'd1:    byte_mask = 8'h03;
            2'd2:    byte_mask = 8'h0F;
            default: byte_mask = 8'hFF;
        endcase
        be      = byte_mask << addr[2:0];
        wlane   = wdata << {addr[2:0], 3'b000};
        pw      = (size == 2'd3) ? wdata : {32'b0, wdata[31:0]};
        ram_we  = wmem & ok & ram_hit;
        led_we  = wmem & ok & led_hit;
        cyc_we  = wmem & ok & cyc_hit;
        push    = wmem & ok & uart_hit;
        leds_d  = led_we ? pw[7:0] : leds_q;
        cyc_d   = cyc_we ? pw : cyc_q + 64'd1;
        fault_d = fault_q | (access & bad);
    end

    // NOTE: RAM and FIFO storage carry no reset; only the pointers and flags that qualify them do.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int b = 0; b < 8; b++) begin
                if (be[b]) ram_q[ram_idx][8*b +: 8] <= wlane[8*b +: 8];
            end
        end
        if (push_ok) fifo_q[wr_ptr_q] <= wdata[7:0];
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        baud_done = baud_q == BAUD_LAST;
        pop       = (count_q != '0) &&
                    ((state_q == ST_IDLE) || (state_q == ST_STOP && baud_done));
        push_ok   = push && ((count_q != DEPTH_CNT) || pop);
        ovf_d     = ovf_q | (push & ~push_ok);
        wr_ptr_d  = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d  = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        state_d = state_q;
        baud_d  = baud_done ? '0 : baud_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        case (state_q)
            ST_IDLE: baud_d = '0;
            ST_START: begin
                if (baud_done) begin
                    state_d = ST_DATA;
                    bit_d   = 3'd0;
                    tx_d    = shift_q[0];
                end
            end
            ST_DATA: begin
                if (baud_done) begin
                    if (bit_q == 3'd7) begin
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end
            end
            default: begin
                if (baud_done) state_d = ST_IDLE;
            end
        endcase
        // Popping from IDLE or at the end of STOP starts the next frame with no idle gap.
        if (pop) begin
            state_d = ST_START;
            baud_d  = '0;
            shift_d = fifo_q[rd_ptr_q];
            tx_d    = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            leds_q   <= 8'd0;
            cyc_q    <= 64'd0;
            fault_q  <= 1'b0;
            ovf_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= ST_IDLE;
            baud_q   <= '0;
            bit_q    <= 3'd0;
            shift_q  <= 8'd0;
            tx_q     <= 1'b1;
        end else begin
            leds_q   <= leds_d;
            cyc_q    <= cyc_d;
            fault_q  <= fault_d;
            ovf_q    <= ovf_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
        end
    end

    assign leds    = leds_q;
    assign uart_tx = tx_q;
    assign fault   = fault_q;

endmodule
